// File: rtl/uart_cmd_arb_if.sv
// Requester-side and UART-side handshake bundle for the shared UART command arbiter.
interface uart_cmd_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int CMD_WIDTH  = 16,
  parameter int READ_WIDTH = 8
);
  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
  logic [NUM_REQ-1:0]           req_vld;
  logic [NUM_REQ-1:0]           req_rdy;
  logic [READ_WIDTH-1:0]        rsp_data;
  logic [NUM_REQ-1:0]           rsp_vld;
  logic [NUM_REQ-1:0]           rsp_err;
  logic [CMD_WIDTH-1:0]         cmd_in;
  logic                         cmd_vld;
  logic                         cmd_rdy;
  logic                         read_rdy;
  logic [READ_WIDTH-1:0]        read_data;
  logic                         busy;

  modport master (
    input  req_cmd, req_vld, cmd_rdy, read_rdy, read_data,
    output req_rdy, rsp_data, rsp_vld, rsp_err, cmd_in, cmd_vld, busy
  );
  modport slave (
    output req_cmd, req_vld, cmd_rdy, read_rdy, read_data,
    input  req_rdy, rsp_data, rsp_vld, rsp_err, cmd_in, cmd_vld, busy
  );
endinterface

// File: rtl/uart_cmd_arb.sv
// Round-robin arbiter sharing one UART command port among NUM_REQ requesters,
// with read-data routing back to the issuing requester and a read timeout.
module uart_cmd_arb_lane (
  input  logic clk,
  input  logic rst,
  input  logic take,
  input  logic is_win,
  input  logic is_own,
  input  logic hit,
  input  logic tmo,
  output logic q_rdy,
  output logic q_vld,
  output logic q_err
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rdy <= 1'b0;
      q_vld <= 1'b0;
      q_err <= 1'b0;
    end else begin
      q_rdy <= take & is_win;
      q_vld <= hit & is_own;
      q_err <= tmo & is_own;
    end
  end
endmodule

module uart_cmd_arb #(
  parameter int          NUM_REQ    = 4,
  parameter int          CMD_WIDTH  = 16,
  parameter int          READ_WIDTH = 8,
  parameter logic [15:0] TIMEOUT    = 16'd60000
) (
  input logic            clk,
  input logic            rst,
  uart_cmd_arb_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, WAIT_RSP} state_t;

  state_t                state, state_d;
  logic [IW-1:0]         rr_ptr, grant, win_idx;
  logic                  win_found, take, rd_hit, rd_tmo;
  logic [CMD_WIDTH-1:0]  cmd_lat;
  logic [15:0]           tcnt;
  logic [NUM_REQ-1:0]    rdy_q, vld_q, err_q;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NUM_REQ-1)) ? '0 : v + 1'b1;
  endfunction

  // First set req_vld searching upward from rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    logic [IW-1:0] scan;
    win_found = 1'b0;
    win_idx   = '0;
    scan      = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.req_vld[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    take    = 1'b0;
    rd_hit  = 1'b0;
    rd_tmo  = 1'b0;
    case (state)
      IDLE: if (win_found) begin
        state_d = ISSUE;
        take    = 1'b1;
      end
      ISSUE:     if (bus.cmd_vld && bus.cmd_rdy) state_d = WAIT_BUSY;
      WAIT_BUSY: if (!bus.cmd_rdy) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.cmd_rdy) state_d = cmd_lat[CMD_WIDTH-1] ? WAIT_RSP : IDLE;
      WAIT_RSP: begin
        // Data arriving on the timeout cycle takes priority over the error.
        if (bus.read_rdy) begin
          rd_hit  = 1'b1;
          state_d = IDLE;
        end else if (tcnt == TIMEOUT - 16'd1) begin
          rd_tmo  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      grant        <= '0;
      cmd_lat      <= '0;
      tcnt         <= '0;
      bus.cmd_vld  <= 1'b0;
      bus.cmd_in   <= '0;
      bus.rsp_data <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          grant   <= win_idx;
          cmd_lat <= bus.req_cmd[win_idx*CMD_WIDTH +: CMD_WIDTH];
          rr_ptr  <= wrap_inc(win_idx);
        end
        ISSUE: begin
          if (!bus.cmd_vld) begin
            bus.cmd_vld <= 1'b1;
            bus.cmd_in  <= cmd_lat;
          end else if (bus.cmd_rdy) begin
            bus.cmd_vld <= 1'b0;
          end
        end
        WAIT_DONE: tcnt <= '0;
        WAIT_RSP: begin
          if (rd_hit) bus.rsp_data <= bus.read_data;
          else        tcnt <= tcnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    uart_cmd_arb_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .take   (take),
      .is_win (win_idx == IW'(gi)),
      .is_own (grant == IW'(gi)),
      .hit    (rd_hit),
      .tmo    (rd_tmo),
      .q_rdy  (rdy_q[gi]),
      .q_vld  (vld_q[gi]),
      .q_err  (err_q[gi])
    );
  end

  assign bus.req_rdy = rdy_q;
  assign bus.rsp_vld = vld_q;
  assign bus.rsp_err = err_q;
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_cmd_arb.sv
// Directed bench for uart_cmd_arb: vector table plus timeout, race, spurious and reset sequences.
module tb_uart_cmd_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_cmd_arb_if #(.NUM_REQ(4), .CMD_WIDTH(16), .READ_WIDTH(8)) bus ();

  uart_cmd_arb #(.NUM_REQ(4), .CMD_WIDTH(16), .READ_WIDTH(8), .TIMEOUT(16'd100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [63:0] cmds;
    int          g;
    logic [15:0] exp_cmd;
    bit          drop;
    int          stall;
    bit          rd;
    logic [7:0]  rdata;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic grant_phase(input int g, input bit drop);
    logic [3:0] oh;
    int n = 0;
    oh = 4'b0001 << g;
    while (bus.req_rdy == 4'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_rdy", 64'(bus.req_rdy), 64'(oh));
    chk("cmd_vld_at_grant", 64'(bus.cmd_vld), 64'd0);
    chk("busy_at_grant", 64'(bus.busy), 64'd1);
    if (drop) bus.req_vld = 4'b0;
  endtask

  task automatic cmd_phase(input logic [15:0] exp, input int stall);
    bus.cmd_rdy = (stall == 0);
    @(negedge clk);
    chk("cmd_vld", 64'(bus.cmd_vld), 64'd1);
    chk("cmd_in", 64'(bus.cmd_in), 64'(exp));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("cmd_hold", 64'({bus.cmd_vld, bus.cmd_in}), 64'({1'b1, exp}));
    end
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
    chk("cmd_vld_drop", 64'(bus.cmd_vld), 64'd0);
  endtask

  task automatic busy_phase();
    bus.cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_uart", 64'(bus.busy), 64'd1);
    bus.cmd_rdy = 1'b1;
  endtask

  task automatic write_tail();
    @(negedge clk);
    chk("busy_after_write", 64'(bus.busy), 64'd0);
    chk("no_rsp_write", 64'({bus.rsp_vld, bus.rsp_err}), 64'd0);
  endtask

  task automatic read_tail(input int g, input logic [7:0] d, input logic [7:0] exp_d);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    repeat (2) @(negedge clk);
    bus.read_rdy  = 1'b1;
    bus.read_data = d;
    @(negedge clk);
    chk("rsp_vld", 64'(bus.rsp_vld), 64'(oh));
    chk("rsp_data", 64'(bus.rsp_data), 64'(exp_d));
    chk("rsp_err_read", 64'(bus.rsp_err), 64'd0);
    chk("busy_after_read", 64'(bus.busy), 64'd0);
    bus.read_rdy = 1'b0;
    @(negedge clk);
    chk("rsp_vld_pulse", 64'(bus.rsp_vld), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early;
    vecs[0]  = '{4'b1111, 64'h0403_0302_0201_0100, 0, 16'h0100, 1'b0, 2, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{4'b1111, 64'h0403_0302_0201_0100, 1, 16'h0201, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{4'b1111, 64'h0403_0302_0201_0100, 2, 16'h0302, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{4'b1111, 64'h0403_0302_0201_0100, 3, 16'h0403, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{4'b1111, 64'h0403_0302_0201_0100, 0, 16'h0100, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[5]  = '{4'b1111, 64'h0403_0302_0201_0100, 1, 16'h0201, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[6]  = '{4'b1010, 64'h0403_0302_0201_0100, 3, 16'h0403, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{4'b1010, 64'h0403_0302_0201_0100, 1, 16'h0201, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{4'b1010, 64'h0403_0302_0201_0100, 3, 16'h0403, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[9]  = '{4'b1010, 64'h0403_0302_0201_0100, 1, 16'h0201, 1'b1, 0, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{4'b0001, 64'h0000_0000_0000_1234, 0, 16'h1234, 1'b1, 1, 1'b0, 8'h00, 8'h00};
    vecs[11] = '{4'b0100, 64'h0000_8A00_0000_0000, 2, 16'h8A00, 1'b1, 0, 1'b1, 8'h5C, 8'h5C};
    vecs[12] = '{4'b0010, 64'h0000_0000_8101_0000, 1, 16'h8101, 1'b1, 0, 1'b1, 8'hA7, 8'hA7};
    vecs[13] = '{4'b1011, 64'h0C33_0000_0C11_0C00, 3, 16'h0C33, 1'b1, 0, 1'b0, 8'h00, 8'h00};

    bus.req_vld   = 4'b0;
    bus.req_cmd   = '0;
    bus.cmd_rdy   = 1'b1;
    bus.read_rdy  = 1'b0;
    bus.read_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bus.req_rdy, bus.rsp_vld, bus.rsp_err, bus.cmd_vld, bus.busy}), 64'd0);
    chk("reset_data", 64'({bus.cmd_in, bus.rsp_data}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      bus.req_vld = vecs[i].vld;
      bus.req_cmd = vecs[i].cmds;
      grant_phase(vecs[i].g, vecs[i].drop);
      cmd_phase(vecs[i].exp_cmd, vecs[i].stall);
      busy_phase();
      if (vecs[i].rd) read_tail(vecs[i].g, vecs[i].rdata, vecs[i].exp_data);
      else            write_tail();
    end

    // Timeout: requester 3 reads, no data ever arrives.
    bus.req_cmd = 64'h8003_0000_0000_0000;
    bus.req_vld = 4'b1000;
    grant_phase(3, 1'b1);
    cmd_phase(16'h8003, 0);
    busy_phase();
    early = 1'b0;
    for (int n = 1; n <= 101; n++) begin
      @(negedge clk);
      if (n < 101 && (bus.rsp_err != 4'b0 || bus.rsp_vld != 4'b0)) early = 1'b1;
    end
    chk("timeout_early_pulse", 64'(early), 64'd0);
    chk("timeout_err", 64'(bus.rsp_err), 64'h8);
    chk("timeout_no_vld", 64'(bus.rsp_vld), 64'd0);
    chk("timeout_data_kept", 64'(bus.rsp_data), 64'hA7);
    @(negedge clk);
    chk("timeout_err_pulse", 64'({bus.rsp_err, bus.busy}), 64'd0);

    // Data on the exact timeout cycle wins over the error.
    bus.req_cmd = 64'h0000_0000_8111_0000;
    bus.req_vld = 4'b0010;
    grant_phase(1, 1'b1);
    cmd_phase(16'h8111, 0);
    busy_phase();
    early = 1'b0;
    for (int n = 1; n <= 101; n++) begin
      @(negedge clk);
      if (n < 101 && (bus.rsp_err != 4'b0 || bus.rsp_vld != 4'b0)) early = 1'b1;
      if (n == 100) begin
        bus.read_rdy  = 1'b1;
        bus.read_data = 8'h3E;
      end
    end
    chk("race_early_pulse", 64'(early), 64'd0);
    chk("race_vld", 64'(bus.rsp_vld), 64'h2);
    chk("race_no_err", 64'(bus.rsp_err), 64'd0);
    chk("race_data", 64'(bus.rsp_data), 64'h3E);
    bus.read_rdy = 1'b0;
    @(negedge clk);

    // Spurious read_rdy while idle is ignored.
    bus.read_rdy  = 1'b1;
    bus.read_data = 8'hFF;
    @(negedge clk);
    bus.read_rdy = 1'b0;
    @(negedge clk);
    chk("spurious_data", 64'(bus.rsp_data), 64'h3E);
    chk("spurious_pulse", 64'({bus.rsp_vld, bus.rsp_err, bus.busy}), 64'd0);

    // Reset while waiting for read data.
    bus.req_cmd = 64'h0000_8B02_0000_0000;
    bus.req_vld = 4'b0100;
    grant_phase(2, 1'b1);
    cmd_phase(16'h8B02, 0);
    busy_phase();
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midreset_ctl", 64'({bus.req_rdy, bus.rsp_vld, bus.rsp_err, bus.cmd_vld, bus.busy}), 64'd0);
    chk("midreset_data", 64'({bus.cmd_in, bus.rsp_data}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    early = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_vld != 4'b0 || bus.rsp_err != 4'b0 || bus.busy) early = 1'b1;
    end
    chk("post_reset_quiet", 64'(early), 64'd0);
    bus.req_cmd = 64'h0D33_0000_0D11_0D00;
    bus.req_vld = 4'b1011;
    grant_phase(0, 1'b1);
    cmd_phase(16'h0D00, 0);
    busy_phase();
    write_tail();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
